bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter for the four-master shared bus. Samples the active-low bus request of each master and drives the four active-low grant lines that select which master's address, strobe, R/W and write data reach the slaves. A hold-time limit forces rotation, so no master can starve the others during long bursts. Sits beside the master multiplexer in the bus top level; its grant outputs are that multiplexer's select inputs and are also returned to each master.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one master keeps the bus while another master is requesting; 0 disables preemption.
- HOLD_W, 5: width of the hold counter; must hold MAX_HOLD.
- clk  in  1  bus clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req_ … m3_req_  in  1 each  bus request, active low (`ENABLE_` = 0).
- m0_grnt_ … m3_grnt_  out  1 each  bus grant, active low, registered.
- bus_owner  out  2  index of the granted master; valid only when bus_busy = 1.
- bus_busy  out  1  high while any grant is asserted.

## Operation
- State: `IDLE` (no grant) and `OWNED` (one grant asserted); registers owner[1:0], last[1:0] (last granted master), hold_cnt[HOLD_W-1:0].
- Round-robin search order: last+1, last+2, last+3, last (mod 4); the first requester in that order wins.
- `IDLE`: if any req_ is low, go to `OWNED`, owner = winner, last = winner, hold_cnt = 0. Otherwise stay in `IDLE`.
- `OWNED`, owner's req_ low, no preemption: stay. hold_cnt increments and saturates at MAX_HOLD.
- Preemption: MAX_HOLD ≠ 0, hold_cnt == MAX_HOLD-1, owner still requesting, and at least one other master requesting. The grant moves to the first *other* requester in round-robin order. last = new owner; hold_cnt = 0.
- Preemption condition with no other requester: owner keeps the bus and hold_cnt saturates. Preemption occurs on the first cycle any other master then requests.
- Owner's req_ high (release): if other requests are pending, hand over directly to the round-robin winner (stay in `OWNED`, hold_cnt = 0, last updated). Otherwise go to `IDLE` with all grants deasserted. The released master's grant always drops on this edge.
- Release and hold expiry in the same cycle: treated as a release.
- Invariant: at most one m*_grnt_ low in any cycle. bus_owner equals the index of the low grant.
- Masters must keep req_ low for the whole transfer. The arbiter neither inspects as_ nor waits for it.

## Timing
- Reset values (registered on the clk edge where reset = 1): all m*_grnt_ = 1, bus_busy = 0, bus_owner = 0, last = 3 (so m0 wins the first contention), hold_cnt = 0, state `IDLE`. Reset overrides every other condition, including mid-ownership.
- Request-to-grant latency: 1 cycle. req_ is sampled low at edge N; grant is low after edge N, visible in cycle N+1.
- Release-to-grant-drop latency: 1 cycle. Handover has zero dead cycles: the old grant rises and the new grant falls on the same edge.
- Maximum continuous ownership under contention: MAX_HOLD cycles of grant.
- Worst-case wait for a continuously requesting master under full contention: 3 × MAX_HOLD + 1 cycles.

## Test plan
- Reset then single request: after reset, hold m2_req_ = 0 → m2_grnt_ = 0 one cycle later, bus_owner = 2, bus_busy = 1. Release m2_req_ → all grants 1 and bus_busy = 0 one cycle later.
- Simultaneous first request: straight after reset, all four req_ = 0 → m0 granted first. Each release then grants m1, m2, m3, m0 in that order, with no idle cycle between owners.
- Preemption, MAX_HOLD = 4: m1 and m3 hold req_ = 0 continuously → m1 granted for exactly 4 cycles, then m3 for 4, then m1 again. Never two grants low at once.
- Saturation with no contention: m0 alone requests for 40 cycles → grant held for all 40. m2 then requests → m0 is preempted on the next edge and m2_grnt_ = 0.
- Release coinciding with expiry, and MAX_HOLD = 0: release coinciding with expiry is handled as a normal release to the next requester. With MAX_HOLD = 0, an owner holding for 100 cycles against a waiting master is never preempted.
- Reset mid-ownership: assert reset while m3 is owner and m1 is requesting → all grants 1 the next cycle. After reset is released, m1 is granted one cycle later.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// All request and grant lines are active low.
interface bus_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    logic [1:0] bus_owner;
    logic       bus_busy;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, bus_busy
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, bus_busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the four-master shared bus, with a hold-time limit
// that forces rotation while other masters are waiting.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    typedef enum logic {IDLE, OWNED} state_t;

    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_EXP  = PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        grnt_n;
    logic              busy;

    logic [3:0] req;
    logic       rr_valid;
    logic [1:0] rr_win;
    logic       other_valid;
    logic [1:0] other_win;
    logic       grant_en;
    logic [1:0] grant_idx;
    logic       go_idle;

    assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

    // Loops run backwards so the earliest position in the search order wins.
    always_comb begin
        rr_valid    = 1'b0;
        rr_win      = last;
        other_valid = 1'b0;
        other_win   = owner;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                rr_valid = 1'b1;
                rr_win   = last + 2'(i);
            end
        end
        for (int i = 3; i >= 1; i--) begin
            if (req[owner + 2'(i)]) begin
                other_valid = 1'b1;
                other_win   = owner + 2'(i);
            end
        end
    end

    // A release takes priority over hold expiry when both happen together.
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = rr_win;
        go_idle   = 1'b0;
        case (state)
            IDLE: grant_en = rr_valid;
            OWNED: begin
                if (!req[owner]) begin
                    grant_en = rr_valid;
                    go_idle  = !rr_valid;
                end else if (PREEMPT_EN && hold_cnt >= HOLD_EXP && other_valid) begin
                    grant_en  = 1'b1;
                    grant_idx = other_win;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= '0;
            grnt_n   <= 4'hF;
            busy     <= 1'b0;
        end else if (grant_en) begin
            state    <= OWNED;
            owner    <= grant_idx;
            last     <= grant_idx;
            hold_cnt <= '0;
            grnt_n   <= ~(4'b0001 << grant_idx);
            busy     <= 1'b1;
        end else if (go_idle) begin
            state    <= IDLE;
            hold_cnt <= '0;
            grnt_n   <= 4'hF;
            busy     <= 1'b0;
        end else if (state == OWNED && hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.m0_grnt_  = grnt_n[0];
    assign bus.m1_grnt_  = grnt_n[1];
    assign bus.m2_grnt_  = grnt_n[2];
    assign bus.m3_grnt_  = grnt_n[3];
    assign bus.bus_owner = owner;
    assign bus.bus_busy  = busy;

endmodule
